// File: rtl/scroller_pkg.sv
// Shared definitions for the phrase scroller: state encoding, mode codes
// and the default blank character.
package scroller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        CYCLE = 2'd2
    } state_t;

    localparam logic MODE_PAGE   = 1'b0;
    localparam logic MODE_SCROLL = 1'b1;

    localparam logic [4:0] DEFAULT_BLANK = 5'b11111;

endpackage

// File: rtl/tick_divider.sv
// Advance-tick generator: counts enabled clk cycles and emits a one-cycle
// tick on the last count of each TICK_DIV-cycle period.
module tick_divider #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == TERM_CNT);

    // Count while enabled, wrap on terminal count; clear dominates enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phrase_scroller.sv
// Phrase display engine: latches a phrase and shows a DISP_CHARS-wide window
// that pages or scrolls on each divided-clock tick.
// Optional feature macro: SCROLLER_PAUSE_EN adds a pause input that freezes
// the tick count, offset and display.
//
// state | meaning
// IDLE  | no phrase held, display all blanks
// SHOW  | phrase fits on the display, static
// CYCLE | phrase longer than the display, advancing on ticks
module phrase_scroller
    import scroller_pkg::*;
#(
    parameter int                CHAR_W     = 5,
    parameter int                DISP_CHARS = 8,
    parameter int                MAX_CHARS  = 16,
    parameter int                TICK_DIV   = 100_000_000,
    parameter logic [CHAR_W-1:0] BLANK_CODE = CHAR_W'(DEFAULT_BLANK)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [MAX_CHARS*CHAR_W-1:0]      phrase_data,
    input  logic [$clog2(MAX_CHARS+1)-1:0]   phrase_len,
    input  logic                             mode,
`ifdef SCROLLER_PAUSE_EN
    input  logic                             pause,
`endif
    output logic [DISP_CHARS*CHAR_W-1:0]     display,
    output logic                             wrap,
    output logic                             busy
);

    localparam int LEN_W = $clog2(MAX_CHARS + 1);
    localparam int OFF_W = $clog2(MAX_CHARS + DISP_CHARS);
    localparam int IDX_W = $clog2(MAX_CHARS);

    state_t                         r_state, w_state_nxt;
    logic [CHAR_W-1:0]              r_buf [MAX_CHARS];
    logic [CHAR_W-1:0]              w_buf_nxt [MAX_CHARS];
    logic [LEN_W-1:0]               r_len, w_len_nxt, w_len_eff;
    logic                           r_mode, w_mode_nxt;
    logic [OFF_W-1:0]               r_offset, w_offset_nxt;
    logic [DISP_CHARS*CHAR_W-1:0]   r_display, w_display_nxt;
    logic                           r_wrap, w_wrap_nxt;
    logic [31:0]                    w_sum;
    logic                           w_tick, w_pause, w_cnt_en;

`ifdef SCROLLER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_cnt_en = (r_state == CYCLE) && !w_pause;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (w_cnt_en),
        .clr  (load),
        .tick (w_tick)
    );

    // Load (priority) or tick advance: next state, buffer, length and offset.
    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_len_nxt    = r_len;
        w_mode_nxt   = r_mode;
        w_offset_nxt = r_offset;
        w_wrap_nxt   = 1'b0;
        w_len_eff    = '0;
        w_sum        = '0;
        if (load) begin
            w_len_eff = (32'(phrase_len) > 32'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : phrase_len;
            for (int k = 0; k < MAX_CHARS; k++) begin
                w_buf_nxt[k] = phrase_data[(MAX_CHARS-1-k)*CHAR_W +: CHAR_W];
            end
            w_len_nxt    = w_len_eff;
            w_mode_nxt   = mode;
            w_offset_nxt = '0;
            if (w_len_eff == '0) begin
                w_state_nxt = IDLE;
            end else if (32'(w_len_eff) <= 32'(DISP_CHARS)) begin
                w_state_nxt = SHOW;
            end else begin
                w_state_nxt = CYCLE;
            end
        end else if (w_tick) begin
            if (r_mode == MODE_SCROLL) begin
                w_sum = 32'(r_offset) + 32'd1;
                // Only reached in CYCLE, where r_len > DISP_CHARS, so no underflow.
                if (w_sum > 32'(r_len) - 32'(DISP_CHARS)) begin
                    w_offset_nxt = '0;
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_offset_nxt = OFF_W'(w_sum);
                end
            end else begin
                w_sum = 32'(r_offset) + 32'(DISP_CHARS);
                if (w_sum >= 32'(r_len)) begin
                    w_offset_nxt = '0;
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_offset_nxt = OFF_W'(w_sum);
                end
            end
        end
    end

    // Window mux built from next-cycle values so display lands with the offset.
    always_comb begin
        w_display_nxt = '0;
        for (int unsigned i = 0; i < DISP_CHARS; i++) begin
            logic [31:0] idx;
            idx = 32'(w_offset_nxt) + 32'(i);
            if (idx < 32'(w_len_nxt)) begin
                w_display_nxt[(DISP_CHARS-1-i)*CHAR_W +: CHAR_W] = w_buf_nxt[idx[IDX_W-1:0]];
            end else begin
                w_display_nxt[(DISP_CHARS-1-i)*CHAR_W +: CHAR_W] = BLANK_CODE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phrase buffer, offset and registered display/wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_CHARS; k++) begin
                r_buf[k] <= BLANK_CODE;
            end
            r_len     <= '0;
            r_mode    <= MODE_PAGE;
            r_offset  <= '0;
            r_display <= {DISP_CHARS{BLANK_CODE}};
            r_wrap    <= 1'b0;
        end else begin
            r_buf     <= w_buf_nxt;
            r_len     <= w_len_nxt;
            r_mode    <= w_mode_nxt;
            r_offset  <= w_offset_nxt;
            r_display <= w_display_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign display = r_display;
    assign wrap    = r_wrap;
    assign busy    = (r_state == CYCLE);

endmodule
